// File: rtl/tcp_rx_arbiter.sv
// tcp_rx_arbiter
// Packet-granular round-robin arbiter that shares one TCP header disassembler
// between N_PORTS ingress byte streams. A port is granted in IDLE and holds
// the grant (LOCKED) until its last byte transfers. The granted stream is
// passed through combinationally and tagged with its port index.
//
// Optional feature: define TCP_RX_ARB_TIMEOUT_EN to abort a grant that has
// stalled for TIMEOUT_CYC consecutive cycles without a transfer. The abort
// raises dis_abort_o for one cycle and returns to IDLE. Without the macro
// the lock is held indefinitely and dis_abort_o is tied low.
module tcp_rx_arbiter #(
    parameter int N_PORTS     = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_PORTS-1:0]         req_valid_i,
    input  logic [N_PORTS*DATA_W-1:0]  req_data_i,
    input  logic [N_PORTS-1:0]         req_last_i,
    output logic [N_PORTS-1:0]         req_ready_o,
    output logic                       dis_valid_o,
    output logic [DATA_W-1:0]          dis_data_o,
    output logic                       dis_last_o,
    input  logic                       dis_ready_i,
    output logic [$clog2(N_PORTS)-1:0] dis_port_o,
    output logic                       dis_abort_o,
    output logic [N_PORTS-1:0]         grant_o,
    output logic                       busy_o
);

    localparam int IDX_W = $clog2(N_PORTS);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Elaboration-time sanity checks on the configuration.
    if (N_PORTS < 2 || N_PORTS > 16) begin : g_bad_ports
        $error("tcp_rx_arbiter: N_PORTS must be in 2..16");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("tcp_rx_arbiter: TIMEOUT_CYC must be at least 2");
    end

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] next_rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] next_gnt_idx;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic [IDX_W-1:0] after_gnt;

    logic              locked;
    logic              cur_valid;
    logic              cur_last;
    logic [DATA_W-1:0] cur_data;
    logic              xfer;
    logic              pkt_end;
    logic              timeout;

    // Granted lane, selected straight from the inputs (no registered latency).
    assign locked    = (state == LOCKED);
    assign cur_valid = req_valid_i[gnt_idx];
    assign cur_last  = req_last_i[gnt_idx];
    assign cur_data  = req_data_i[gnt_idx*DATA_W +: DATA_W];

    assign xfer    = locked && cur_valid && dis_ready_i;
    assign pkt_end = xfer && cur_last;

    // The port after the current grant becomes the top priority next round,
    // which pushes a just-served port to the bottom.
    assign after_gnt = (gnt_idx == IDX_W'(N_PORTS - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef TCP_RX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [CNT_W-1:0] stall_cnt;

    // The counter only ever reaches TIMEOUT_CYC-1, so it never saturates.
    assign timeout = locked && !xfer && (stall_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Stall counter: counts locked cycles without a transfer, cleared on any
    // transfer, on abort and whenever the arbiter is not locked.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (!locked || xfer || timeout) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Round-robin search: first valid port at or above rr_ptr, wrapping to 0.
    always_comb begin
        int cand;
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            cand = (int'(rr_ptr) + i) % N_PORTS;
            if (!pick_found && req_valid_i[IDX_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // State register: FSM state, round-robin pointer and granted index.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gnt_idx <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            state   <= next_state;
            rr_ptr  <= next_rr_ptr;
            gnt_idx <= next_gnt_idx;
        end
    end

    // Next-state logic: grant on any request in IDLE, release on last byte
    // or on a stall abort.
    always_comb begin
        next_state   = state;
        next_rr_ptr  = rr_ptr;
        next_gnt_idx = gnt_idx;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    next_state   = LOCKED;
                    next_gnt_idx = pick_idx;
                end
            end
            LOCKED: begin
                if (pkt_end || timeout) begin
                    next_state  = IDLE;
                    next_rr_ptr = after_gnt;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output logic: pass the granted lane through while locked, all zeros
    // otherwise (including during reset, since state resets asynchronously).
    always_comb begin
        req_ready_o = '0;
        dis_valid_o = 1'b0;
        dis_data_o  = '0;
        dis_last_o  = 1'b0;
        dis_port_o  = '0;
        grant_o     = '0;
        busy_o      = 1'b0;
        dis_abort_o = timeout;
        if (locked) begin
            dis_valid_o          = cur_valid;
            dis_data_o           = cur_data;
            dis_last_o           = cur_last;
            dis_port_o           = gnt_idx;
            req_ready_o[gnt_idx] = dis_ready_i;
            grant_o[gnt_idx]     = 1'b1;
            busy_o               = 1'b1;
        end
    end

endmodule

// File: tb/tb_tcp_rx_arbiter.sv
// Self-checking bench for tcp_rx_arbiter (4 ports, 8-bit data, TIMEOUT_CYC=16).
// Table-driven vectors cover the basic packet flow, the round-robin order and
// the re-request priority case; hand-written sequences cover backpressure,
// asynchronous reset and the stall timeout.
module tb_tcp_rx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        dis_valid;
    logic [7:0]  dis_data;
    logic        dis_last;
    logic        dis_ready;
    logic [1:0]  dis_port;
    logic        dis_abort;
    logic [3:0]  grant;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        rdy;
        logic        e_dv;
        logic [7:0]  e_data;
        logic        e_last;
        logic [1:0]  e_port;
        logic [3:0]  e_grant;
        logic [3:0]  e_ready;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    tcp_rx_arbiter #(
        .N_PORTS    (4),
        .DATA_W     (8),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_valid),
        .req_data_i (req_data),
        .req_last_i (req_last),
        .req_ready_o(req_ready),
        .dis_valid_o(dis_valid),
        .dis_data_o (dis_data),
        .dis_last_o (dis_last),
        .dis_ready_i(dis_ready),
        .dis_port_o (dis_port),
        .dis_abort_o(dis_abort),
        .grant_o    (grant),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_dv, input logic [7:0] e_data,
                              input logic e_last, input logic [1:0] e_port,
                              input logic [3:0] e_grant, input logic [3:0] e_ready,
                              input logic e_busy);
        check({tag, ".dis_valid"}, 32'(dis_valid), 32'(e_dv));
        check({tag, ".dis_data"},  32'(dis_data),  32'(e_data));
        check({tag, ".dis_last"},  32'(dis_last),  32'(e_last));
        check({tag, ".dis_port"},  32'(dis_port),  32'(e_port));
        check({tag, ".grant"},     32'(grant),     32'(e_grant));
        check({tag, ".req_ready"}, 32'(req_ready), 32'(e_ready));
        check({tag, ".busy"},      32'(busy),      32'(e_busy));
        check({tag, ".dis_abort"}, 32'(dis_abort), 32'd0);
    endtask

    task automatic add_vec(input logic [3:0] valid, input logic [31:0] data,
                           input logic [3:0] last, input logic rdy,
                           input logic e_dv, input logic [7:0] e_data, input logic e_last,
                           input logic [1:0] e_port, input logic [3:0] e_grant,
                           input logic [3:0] e_ready, input logic e_busy);
        vec_t v;
        v.valid   = valid;
        v.data    = data;
        v.last    = last;
        v.rdy     = rdy;
        v.e_dv    = e_dv;
        v.e_data  = e_data;
        v.e_last  = e_last;
        v.e_port  = e_port;
        v.e_grant = e_grant;
        v.e_ready = e_ready;
        v.e_busy  = e_busy;
        vecs.push_back(v);
    endtask

    // One vector per cycle: drive after the falling edge, compare 1 ns later.
    task automatic run_vecs(input int lo, input int hi, input string grp);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            req_valid = vecs[i].valid;
            req_data  = vecs[i].data;
            req_last  = vecs[i].last;
            dis_ready = vecs[i].rdy;
            #1;
            check_outs($sformatf("%s[%0d]", grp, i - lo), vecs[i].e_dv, vecs[i].e_data,
                       vecs[i].e_last, vecs[i].e_port, vecs[i].e_grant,
                       vecs[i].e_ready, vecs[i].e_busy);
        end
    endtask

    initial begin
        int          seg_a_end;
        int          seg_b_end;
        logic [7:0]  bytes [4];
        logic [7:0]  got[$];
        int          idx;
        bit          done;
        bit          stall;
        int          pulses;
        int          order [5];
        logic [31:0] d;
        logic        e_busy;
        logic        e_abort;
        logic [3:0]  e_grant;

        // ---- vector table --------------------------------------------------
        // Port 2 sends A1 A2 A3 (last); rr_ptr becomes 3.
        add_vec(4'b0100, 32'h00A1_0000, 4'b0000, 1'b1, 0, 8'h00, 0, 2'd0, 4'b0000, 4'b0000, 0);
        add_vec(4'b0100, 32'h00A1_0000, 4'b0000, 1'b1, 1, 8'hA1, 0, 2'd2, 4'b0100, 4'b0100, 1);
        add_vec(4'b0100, 32'h00A2_0000, 4'b0000, 1'b1, 1, 8'hA2, 0, 2'd2, 4'b0100, 4'b0100, 1);
        add_vec(4'b0100, 32'h00A3_0000, 4'b0100, 1'b1, 1, 8'hA3, 1, 2'd2, 4'b0100, 4'b0100, 1);
        add_vec(4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 0, 8'h00, 0, 2'd0, 4'b0000, 4'b0000, 0);
        // Ports 0 and 3 valid with single-byte packets, rr_ptr=3: 3 first,
        // then 0 even though 3 re-requests at its own last transfer.
        add_vec(4'b1001, 32'hC300_00B0, 4'b1001, 1'b1, 0, 8'h00, 0, 2'd0, 4'b0000, 4'b0000, 0);
        add_vec(4'b1001, 32'hC300_00B0, 4'b1001, 1'b1, 1, 8'hC3, 1, 2'd3, 4'b1000, 4'b1000, 1);
        add_vec(4'b1001, 32'hC300_00B0, 4'b1001, 1'b1, 0, 8'h00, 0, 2'd0, 4'b0000, 4'b0000, 0);
        add_vec(4'b1001, 32'hC300_00B0, 4'b1001, 1'b1, 1, 8'hB0, 1, 2'd0, 4'b0001, 4'b0001, 1);
        add_vec(4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 0, 8'h00, 0, 2'd0, 4'b0000, 4'b0000, 0);
        seg_a_end = vecs.size();

        // All ports continuously valid with 2-byte packets from rr_ptr=0:
        // grant order 0,1,2,3,0 with one idle bubble before each packet.
        order = '{0, 1, 2, 3, 0};
        for (int r = 0; r < 5; r++) begin
            for (int beat = 0; beat < 3; beat++) begin
                d = '0;
                for (int k = 0; k < 4; k++) begin
                    d[k*8 +: 8] = (k == order[r] && beat == 2) ? {4'(k), 4'h2} : {4'(k), 4'h1};
                end
                if (beat == 0) begin
                    add_vec(4'b1111, d, 4'b0000, 1'b1, 0, 8'h00, 0, 2'd0, 4'b0000, 4'b0000, 0);
                end else begin
                    add_vec(4'b1111, d, (beat == 2) ? 4'(1 << order[r]) : 4'b0000, 1'b1,
                            1, {4'(order[r]), (beat == 2) ? 4'h2 : 4'h1}, (beat == 2),
                            2'(order[r]), 4'(1 << order[r]), 4'(1 << order[r]), 1);
                end
            end
        end
        add_vec(4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 0, 8'h00, 0, 2'd0, 4'b0000, 4'b0000, 0);
        seg_b_end = vecs.size();

        // ---- reset ---------------------------------------------------------
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        dis_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_outs("reset", 0, 8'h00, 0, 2'd0, 4'b0000, 4'b0000, 0);
        rst = 1'b0;

        // ---- basic packet + re-request priority (table) ----------------------
        run_vecs(0, seg_a_end, "pkt");

        // ---- backpressure on port 1 (rr_ptr=1), other ports also valid -------
        bytes = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
        @(negedge clk);
        req_valid = 4'b1111;
        req_data  = 32'h5555_D155;
        req_last  = 4'b0000;
        dis_ready = 1'b1;
        #1;
        check("bp.idle_busy", 32'(busy), 32'd0);
        idx  = 0;
        done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            stall         = (c >= 2 && c <= 6);
            dis_ready     = !stall;
            req_data      = 32'h5555_0055;
            req_data[15:8] = bytes[idx];
            req_last      = (idx == 3) ? 4'b0010 : 4'b0000;
            #1;
            check($sformatf("bp.grant[%0d]", c), 32'(grant), 32'b0010);
            check($sformatf("bp.port[%0d]", c), 32'(dis_port), 32'd1);
            check($sformatf("bp.ready[%0d]", c), 32'(req_ready), stall ? 32'b0000 : 32'b0010);
            check($sformatf("bp.valid[%0d]", c), 32'(dis_valid), 32'd1);
            check($sformatf("bp.last[%0d]", c), 32'(dis_last), 32'(idx == 3));
            if (!stall) begin
                got.push_back(dis_data);
                if (idx == 3) done = 1'b1;
                idx++;
            end
        end
        check("bp.complete", 32'(done), 32'd1);
        check("bp.count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            check($sformatf("bp.byte[%0d]", i), 32'(got[i]), 32'(bytes[i]));
        end
        @(negedge clk);
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        dis_ready = 1'b1;
        #1;
        check_outs("bp.bubble", 0, 8'h00, 0, 2'd0, 4'b0000, 4'b0000, 0);

        // ---- asynchronous reset mid-packet on port 1 -------------------------
        @(negedge clk);
        req_valid = 4'b0010;
        req_data  = 32'h0000_E100;
        #1;
        check("rst.pre_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        check("rst.locked_valid", 32'(dis_valid), 32'd1);
        check("rst.locked_grant", 32'(grant), 32'b0010);
        @(negedge clk);
        req_data = 32'h0000_E200;
        #1;
        check("rst.mid_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_outs("rst.async", 0, 8'h00, 0, 2'd0, 4'b0000, 4'b0000, 0);
        @(negedge clk);
        @(negedge clk);
        req_valid = 4'b0000;
        rst       = 1'b0;

        // ---- round-robin order with all ports valid (table) -----------------
        run_vecs(seg_a_end, seg_b_end, "rr");

        // ---- stall timeout: port 0 granted then goes quiet (rr_ptr=1) --------
        @(negedge clk);
        req_valid = 4'b0001;
        req_data  = '0;
        req_last  = '0;
        dis_ready = 1'b1;
        #1;
        check("to.idle_busy", 32'(busy), 32'd0);
        pulses = 0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            req_valid = 4'b0010;
            #1;
`ifdef TCP_RX_ARB_TIMEOUT_EN
            e_busy  = (c != 16);
            e_abort = (c == 15);
            e_grant = (c <= 15) ? 4'b0001 : (c == 16) ? 4'b0000 : 4'b0010;
`else
            e_busy  = 1'b1;
            e_abort = 1'b0;
            e_grant = 4'b0001;
`endif
            check($sformatf("to.busy[%0d]", c), 32'(busy), 32'(e_busy));
            check($sformatf("to.abort[%0d]", c), 32'(dis_abort), 32'(e_abort));
            check($sformatf("to.grant[%0d]", c), 32'(grant), 32'(e_grant));
            if (dis_abort) pulses++;
        end
`ifdef TCP_RX_ARB_TIMEOUT_EN
        check("to.pulses", 32'(pulses), 32'd1);
`else
        check("to.pulses", 32'(pulses), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
